// File: rtl/cdb_broadcaster_pkg.sv
// Shared types and widths for the CDB transmit path.
// ROB_TAG_BITS / CDB_N_SRC may be supplied by the build; defaults below.
`ifndef ROB_TAG_BITS
`define ROB_TAG_BITS 6
`endif
`ifndef CDB_N_SRC
`define CDB_N_SRC 4
`endif

package cdb_broadcaster_pkg;
  localparam int TAG_W = `ROB_TAG_BITS;
  localparam int VAL_W = 32;

  typedef enum logic [1:0] {SRC_ALU, SRC_MULT, SRC_LOAD, SRC_BRANCH} src_id_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] value;
  } cdb_entry_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [VAL_W-1:0] value;
  } cdb_packet_t;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result buffer. 'empty' means nothing the arbiter may take yet:
// an entry written at the last edge is held back one cycle (no bypass).
module cdb_src_fifo
  import cdb_broadcaster_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic [VAL_W-1:0] push_value,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic [VAL_W-1:0] head_value,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cdb_entry_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           fresh;
  logic           do_push, do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0) || ((count == CW'(1)) && fresh);
  assign do_push    = push & ~full & ~flush;
  assign do_pop     = pop & ~empty & ~flush;
  assign head_tag   = mem[rd_ptr].tag;
  assign head_value = mem[rd_ptr].value;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= '{tag: push_tag, value: push_value};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      fresh  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      fresh <= do_push;
    end
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// CDB transmit end: per-source buffers, round-robin arbiter, registered broadcast.
// Optional CDB_STATS_EN adds broadcast and per-source stall counters.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int N_SRC      = `CDB_N_SRC,
  parameter int FIFO_DEPTH = 2,
  parameter int SRC_BITS   = $clog2(N_SRC)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*TAG_W-1:0] src_tag,
  input  logic [N_SRC*32-1:0]    src_value,
  output logic [N_SRC-1:0]       src_ready,
  output logic                   cdb_valid,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [31:0]            cdb_value,
  output logic [SRC_BITS-1:0]    cdb_src
`ifdef CDB_STATS_EN
  ,
  output logic [31:0]            stat_bcast,
  output logic [N_SRC*16-1:0]    stat_stall
`endif
);
  logic [N_SRC-1:0]             empty, full, push, pop;
  logic [N_SRC-1:0][TAG_W-1:0]  head_tag;
  logic [N_SRC-1:0][VAL_W-1:0]  head_value;
  logic [SRC_BITS-1:0]          rr_ptr, winner;
  logic                         grant;
  cdb_packet_t                  cdb_q;
  logic [SRC_BITS-1:0]          src_q;

  assign src_ready = reset ? '0 : ~full;
  assign push      = src_valid & src_ready;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign pop[i] = grant && (winner == SRC_BITS'(i));
    cdb_src_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .push       (push[i]),
      .push_tag   (src_tag[i*TAG_W +: TAG_W]),
      .push_value (src_value[i*32 +: 32]),
      .pop        (pop[i]),
      .head_tag   (head_tag[i]),
      .head_value (head_value[i]),
      .empty      (empty[i]),
      .full       (full[i])
    );
  end

  // first non-empty source at or after rr_ptr, wrapping
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!grant && !empty[(int'(rr_ptr) + k) % N_SRC]) begin
        grant  = 1'b1;
        winner = SRC_BITS'((int'(rr_ptr) + k) % N_SRC);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_q  <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      cdb_q.valid <= 1'b0;
    end else if (grant) begin
      cdb_q  <= '{valid: 1'b1, tag: head_tag[winner], value: head_value[winner]};
      src_q  <= winner;
      rr_ptr <= SRC_BITS'((int'(winner) + 1) % N_SRC);
    end else begin
      cdb_q.valid <= 1'b0;
    end
  end

  assign cdb_valid = cdb_q.valid;
  assign cdb_tag   = cdb_q.tag;
  assign cdb_value = cdb_q.value;
  assign cdb_src   = src_q;

`ifdef CDB_STATS_EN
  logic [N_SRC-1:0][15:0] stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_bcast <= '0;
      stall_q    <= '0;
    end else begin
      if (grant && !flush) stat_bcast <= stat_bcast + 32'd1;
      for (int i = 0; i < N_SRC; i++) begin
        if (src_valid[i] && !src_ready[i] && stall_q[i] != 16'hFFFF)
          stall_q[i] <= stall_q[i] + 16'd1;
      end
    end
  end

  assign stat_stall = stall_q;
`endif
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Randomized bench for cdb_broadcaster against a queue-based reference model.
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int SB = 2;

  logic                clock = 1'b0;
  logic                reset, flush;
  logic [N-1:0]        src_valid;
  logic [N*TAG_W-1:0]  src_tag;
  logic [N*32-1:0]     src_value;
  logic [N-1:0]        src_ready;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [31:0]         cdb_value;
  logic [SB-1:0]       cdb_src;
`ifdef CDB_STATS_EN
  logic [31:0]         stat_bcast;
  logic [N*16-1:0]     stat_stall;
`endif

  cdb_broadcaster #(.N_SRC(N), .FIFO_DEPTH(D), .SRC_BITS(SB)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .src_valid(src_valid), .src_tag(src_tag), .src_value(src_value),
    .src_ready(src_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_src(cdb_src)
`ifdef CDB_STATS_EN
    , .stat_bcast(stat_bcast), .stat_stall(stat_stall)
`endif
  );

  always #5 clock = ~clock;

  // reference model: each buffered result remembers the edge that accepted it
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
    int               edge_no;
  } ment_t;

  ment_t            q [N][$];
  int               rr_m, edge_cnt, bcast_m, next_tag;
  int               stall_m [N];
  bit               ev;
  logic [TAG_W-1:0] et;
  logic [31:0]      evl;
  int               es;
  bit               pv [N];
  logic [TAG_W-1:0] pt [N];
  logic [31:0]      pval [N];
  int               passed, total;

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (q[i].size() < D);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      pv[i] = 1'b0;
      stall_m[i] = 0;
    end
    rr_m = 0; ev = 1'b0; bcast_m = 0;
  endtask

  task automatic offer(input int i);
    pv[i]   = 1'b1;
    pt[i]   = TAG_W'(next_tag);
    pval[i] = $urandom;
    next_tag++;
  endtask

  // drive one cycle and advance the model across the coming edge
  task automatic tick(input bit fl);
    bit    rdy [N];
    int    w, idx;
    ment_t e;
    for (int i = 0; i < N; i++) begin
      src_valid[i]                 = pv[i];
      src_tag[i*TAG_W +: TAG_W]    = pt[i];
      src_value[i*32 +: 32]        = pval[i];
      rdy[i]                       = (q[i].size() < D);
      if (pv[i] && !rdy[i]) stall_m[i] = (stall_m[i] >= 65535) ? 65535 : stall_m[i] + 1;
    end
    flush = fl;
    if (fl) begin
      for (int i = 0; i < N; i++) begin q[i].delete(); pv[i] = 1'b0; end
      ev = 1'b0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        idx = (rr_m + k) % N;
        if (w < 0 && q[idx].size() > 0 && q[idx][0].edge_no + 2 <= edge_cnt + 1) w = idx;
      end
      if (w >= 0) begin
        ev = 1'b1; et = q[w][0].tag; evl = q[w][0].value; es = w;
        void'(q[w].pop_front());
        rr_m = (w + 1) % N;
        bcast_m++;
      end else ev = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (pv[i] && rdy[i]) begin
          e.tag = pt[i]; e.value = pval[i]; e.edge_no = edge_cnt + 1;
          q[i].push_back(e);
          pv[i] = 1'b0;
        end
      end
    end
    @(posedge clock);
    edge_cnt++;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (cdb_valid !== 1'b0 || cdb_tag !== '0 || cdb_value !== '0 || cdb_src !== '0 || src_ready !== 4'b0000) begin
      $display("FAIL reset_state got v=%b t=%0d val=%h s=%0d rdy=%b want all 0",
               cdb_valid, cdb_tag, cdb_value, cdb_src, src_ready);
    end else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (src_ready !== 4'b1111) $display("FAIL reset_release_ready got %b want 1111", src_ready);
    else passed++;
    @(negedge clock);
  endtask

  task automatic test_single();
    offer(SRC_ALU);
    pt[0] = 6'd5; pval[0] = 32'h0000_000A;
    for (int c = 0; c < 5; c++) begin
      tick(1'b0);
      total++;
      if (cdb_valid !== ev || (ev && {cdb_tag, cdb_value, cdb_src} !== {et, evl, SB'(es)}))
        $display("FAIL single_model c=%0d got v=%b t=%0d val=%h s=%0d want v=%b t=%0d val=%h s=%0d",
                 c, cdb_valid, cdb_tag, cdb_value, cdb_src, ev, et, evl, es);
      else passed++;
      total++;
      if (cdb_valid !== (c == 2) || (c == 2 && {cdb_tag, cdb_value, cdb_src} !== {6'd5, 32'd10, 2'd0}))
        $display("FAIL single_latency c=%0d got v=%b t=%0d val=%h s=%0d", c, cdb_valid, cdb_tag, cdb_value, cdb_src);
      else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) offer(i);
      tick(1'b0);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (cdb_valid !== 1'b0 || src_ready !== 4'b0000)
      $display("FAIL reset_async got v=%b rdy=%b want v=0 rdy=0000", cdb_valid, src_ready);
    else passed++;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (src_ready !== 4'b1111) $display("FAIL reset_mid_ready got %b want 1111", src_ready);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      tick(1'b0);
      total++;
      if (cdb_valid !== 1'b0) $display("FAIL reset_stale c=%0d got v=%b want 0", c, cdb_valid);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int i = 0; i < N; i++) begin offer(i); pt[i] = TAG_W'(rnd * 4 + i + 1); end
      tick(1'b0);
      tick(1'b0);
      for (int k = 0; k < N; k++) begin
        tick(1'b0);
        total++;
        if (cdb_valid !== 1'b1 || cdb_src !== SB'(k) || cdb_tag !== TAG_W'(rnd * 4 + k + 1))
          $display("FAIL rr_order rnd=%0d k=%0d got v=%b s=%0d t=%0d want v=1 s=%0d t=%0d",
                   rnd, k, cdb_valid, cdb_src, cdb_tag, k, rnd * 4 + k + 1);
        else passed++;
      end
      tick(1'b0);
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) offer(i);
      total++;
      if (src_ready !== model_ready())
        $display("FAIL bp_ready c=%0d got %b want %b", c, src_ready, model_ready());
      else passed++;
      tick(1'b0);
      total++;
      if (cdb_valid !== ev || (ev && {cdb_tag, cdb_value, cdb_src} !== {et, evl, SB'(es)}))
        $display("FAIL bp_bcast c=%0d got v=%b t=%0d val=%h s=%0d want v=%b t=%0d val=%h s=%0d",
                 c, cdb_valid, cdb_tag, cdb_value, cdb_src, ev, et, evl, es);
      else passed++;
    end
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    for (int c = 0; c < 12; c++) tick(1'b0);
  endtask

  task automatic test_flush();
    offer(SRC_ALU); offer(SRC_LOAD); offer(SRC_BRANCH);
    tick(1'b0);
    tick(1'b0);
    offer(SRC_MULT);
    tick(1'b1);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (cdb_valid !== 1'b0) $display("FAIL flush_quiet c=%0d got v=%b want 0", c, cdb_valid);
      else passed++;
      tick(1'b0);
    end
    total++;
    if (src_ready !== 4'b1111) $display("FAIL flush_ready got %b want 1111", src_ready);
    else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) if (!pv[i] && $urandom_range(0, 1) == 1) offer(i);
      total++;
      if (src_ready !== model_ready())
        $display("FAIL rand_ready c=%0d got %b want %b", c, src_ready, model_ready());
      else passed++;
      tick($urandom_range(0, 19) == 0);
      total++;
      if (cdb_valid !== ev || (ev && {cdb_tag, cdb_value, cdb_src} !== {et, evl, SB'(es)}))
        $display("FAIL rand_bcast c=%0d got v=%b t=%0d val=%h s=%0d want v=%b t=%0d val=%h s=%0d",
                 c, cdb_valid, cdb_tag, cdb_value, cdb_src, ev, et, evl, es);
      else passed++;
    end
  endtask

`ifdef CDB_STATS_EN
  task automatic test_stats();
    total++;
    if (stat_bcast !== 32'(bcast_m)) $display("FAIL stat_bcast got %0d want %0d", stat_bcast, bcast_m);
    else passed++;
    for (int i = 0; i < N; i++) begin
      total++;
      if (stat_stall[i*16 +: 16] !== 16'(stall_m[i]))
        $display("FAIL stat_stall%0d got %0d want %0d", i, stat_stall[i*16 +: 16], stall_m[i]);
      else passed++;
    end
  endtask
`endif

  initial begin
    passed = 0; total = 0; edge_cnt = 0; next_tag = 16;
    reset = 1'b1; flush = 1'b0;
    src_valid = '0; src_tag = '0; src_value = '0;
    for (int i = 0; i < N; i++) begin pt[i] = '0; pval[i] = '0; end
    model_reset();
    @(negedge clock);
    @(negedge clock);
    test_reset();
    test_single();
    test_reset_midstream();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_random();
`ifdef CDB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cdb_broadcaster.md
Name: cdb_broadcaster

Overview:
Transmit end of the Common Data Bus. Collects completed results (ROB tag plus 32-bit value) from the functional units. Buffers them per source, arbitrates round-robin, and drives one broadcast per cycle onto cdb_valid/cdb_tag/cdb_value. The map table, reservation stations and reorder buffer consume that broadcast. Flushes all in-flight results on a mispredict clear.

Parameters:
N_SRC, 4, number of producing units (0 ALU, 1 MULT, 2 LOAD, 3 BRANCH)
FIFO_DEPTH, 2, entries per source buffer; must be a power of two, >=2
SRC_BITS, $clog2(N_SRC), width of source index

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
flush  in  1  synchronous squash (driven from rob_clear)
src_valid  in  N_SRC  per-source result valid
src_tag  in  N_SRC*`ROB_TAG_BITS  per-source ROB tag, source i at [i*`ROB_TAG_BITS +: `ROB_TAG_BITS]
src_value  in  N_SRC*32  per-source result, source i at [i*32 +: 32]
src_ready  out  N_SRC  per-source buffer can accept
cdb_valid  out  1  broadcast valid
cdb_tag  out  `ROB_TAG_BITS  broadcast ROB tag
cdb_value  out  32  broadcast value
cdb_src  out  SRC_BITS  index of unit that produced the broadcast

Behaviour:
- Reset (async, immediate): all FIFOs empty, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0. src_ready forced 0 while reset is high.
- Handshake: push for source i occurs on an edge where src_valid[i] & src_ready[i]. src_ready[i] = ~reset & (count[i] != FIFO_DEPTH). It depends on state only, never on src_valid. Producers hold tag/value stable until accepted.
- Per-source FIFO: circular, ptr width $clog2(FIFO_DEPTH), pointers wrap naturally. Push and pop in the same cycle leave count unchanged. A pop never occurs when empty. A push never occurs when full.
- No bypass: an entry pushed at edge k is visible to the arbiter in cycle k+1.
- Arbitration (combinational, each cycle): candidates = sources with count != 0. Winner = first candidate at index rr_ptr, rr_ptr+1, ..., wrapping mod N_SRC.
- On a grant, at the next edge:
  - winner's head is popped;
  - cdb_valid<=1, cdb_tag/cdb_value<=head, cdb_src<=winner;
  - rr_ptr<=(winner+1) mod N_SRC.
- With no candidates: cdb_valid<=0; cdb_tag, cdb_value and cdb_src hold their last values; rr_ptr unchanged.
- Latency: accept at edge k -> earliest cdb_valid high for exactly one cycle after edge k+2. Sustained throughput is one broadcast per cycle.
- Outputs are registered; no combinational path from src_* to cdb_*.
- Fairness: a non-empty source waits at most N_SRC-1 grants.
- flush high at an edge:
  - all FIFOs emptied and cdb_valid<=0;
  - any push offered that cycle is dropped;
  - rr_ptr unchanged.
  - flush has priority over grant and push.
- Simultaneous flush and reset: reset dominates.
- Tag 0 has no special meaning here; it is broadcast like any other.

Optional Feature:
CDB_STATS_EN:
- Defined: adds outputs stat_bcast (32b) and stat_stall (N_SRC*16b).
  - stat_bcast increments on every edge that sets cdb_valid.
  - stat_stall[i] increments each cycle src_valid[i]&~src_ready[i], saturating at 16'hFFFF.
  - Both counters clear on reset only, not on flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- sys_defs.svh gets typedef CDB_PACKET {valid, tag[`ROB_TAG_BITS], value[32]} and `define CDB_N_SRC 4.
- Top-level cdb_* outputs may later be bundled as a CDB_PACKET.
- One sub-module, cdb_src_fifo, is instantiated N_SRC times.
  - Ports: clock, reset, flush, push, push_tag, push_value, pop, head_tag, head_value, empty, full.
- Arbiter and output register stay in the top module.

Test Plan:
- Reset mid-stream: fill all 4 FIFOs, assert reset for a half cycle -> cdb_valid=0 and src_ready=0000 immediately; after release src_ready=1111 and no stale broadcast.
- Single result: ALU pushes tag 5, value 32'h0000_000A at edge 1 -> cdb_valid=1, tag=5, value=10, src=0 in the cycle after edge 3 only.
- Round-robin: all 4 sources push in the same cycle (tags 1,2,3,4) -> broadcasts in order src 0,1,2,3 on consecutive cycles. Next simultaneous set starts at src 0 again (rr_ptr wrapped).
- Backpressure: LOAD pushes every cycle while 3 other sources stay saturated -> src_ready[2] drops after 2 accepts. No tag is lost or duplicated; all values are broadcast in push order.
- Flush: 3 results buffered, flush pulsed with a concurrent MULT push -> cdb_valid=0 next cycle and stays 0. Dropped tags never appear.
- With CDB_STATS_EN: 10 broadcasts plus 3 stalled LOAD cycles -> stat_bcast=10, stat_stall[2]=3, other stall counters 0.
